// File: rtl/pwm_multi_ramp_pkg.sv
// Build defaults, brightness-window helpers and shared types for pwm_multi_ramp.
// The top module additionally honours the optional macro PWM_PHASE_STAGGER_EN.
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif
`ifndef LED_MIN_BRIGHTNESS
`define LED_MIN_BRIGHTNESS 10
`endif
`ifndef LED_MAX_BRIGHTNESS
`define LED_MAX_BRIGHTNESS 90
`endif
`ifndef PWM_CHANNELS
`define PWM_CHANNELS 4
`endif
`ifndef PWM_BR_BOUND
`define PWM_BR_BOUND(w, pct) ((((1 << (w)) - 1) * (pct)) / 100)
`endif

package pwm_multi_ramp_pkg;

    typedef enum logic [1:0] {
        RAMP_HOLD,
        RAMP_UP,
        RAMP_DOWN
    } ramp_dir_t;

    // Clamp bound in counts: full scale times percent, truncated.
    function automatic int br_bound(input int width, input int pct);
        return `PWM_BR_BOUND(width, pct);
    endfunction

endpackage

// File: rtl/pwm_ramp_ch.sv
// One PWM channel: target clamp, per-period ramp toward target, duty register,
// settled flag and registered duty comparator.
module pwm_ramp_ch
    import pwm_multi_ramp_pkg::*;
#(
    parameter int              WIDTH  = 8,
    parameter logic [WIDTH-1:0] BR_MIN = '0,
    parameter logic [WIDTH-1:0] BR_MAX = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             boundary,
    input  logic [WIDTH-1:0] cnt_cmp,
    input  logic [WIDTH-1:0] target,
    input  logic             ramp_en,
    input  logic [WIDTH-1:0] step,
    output logic             pwm,
    output logic [WIDTH-1:0] duty,
    output logic             settled
);

    logic [WIDTH-1:0] tc;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH:0]   gap;
    ramp_dir_t        dir;

    always_comb begin
        tc = target;
        if (tc < BR_MIN) tc = BR_MIN;
        if (tc > BR_MAX) tc = BR_MAX;

        // A zero step would stall the fade forever, so it behaves as one count.
        step_eff = (step == '0) ? WIDTH'(1) : step;

        dir = RAMP_HOLD;
        gap = '0;
        if (duty < tc) begin
            dir = RAMP_UP;
            gap = {1'b0, tc} - {1'b0, duty};
        end else if (duty > tc) begin
            dir = RAMP_DOWN;
            gap = {1'b0, duty} - {1'b0, tc};
        end

        duty_next = duty;
        if (boundary) begin
            if (!ramp_en) begin
                duty_next = tc;
            end else begin
                case (dir)
                    RAMP_UP:   duty_next = (gap > {1'b0, step_eff}) ? duty + step_eff : tc;
                    RAMP_DOWN: duty_next = (gap > {1'b0, step_eff}) ? duty - step_eff : tc;
                    default:   duty_next = duty;
                endcase
            end
        end
    end

    // Comparator uses the values being registered this edge, so a new duty
    // is visible from count 0 of the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty    <= '0;
            pwm     <= 1'b0;
            settled <= 1'b0;
        end else begin
            duty    <= duty_next;
            pwm     <= enb && (cnt_cmp < duty_next);
            settled <= (duty == tc);
        end
    end

endmodule

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM with shared period counter and per-channel clamped, ramped duty.
// Optional macro PWM_PHASE_STAGGER_EN offsets each channel's compare phase by k*(2**WIDTH/CH).
module pwm_multi_ramp
    import pwm_multi_ramp_pkg::*;
#(
    parameter int CH      = `PWM_CHANNELS,
    parameter int WIDTH   = `BRIGHTNESS_WIDTH,
    parameter int MIN_PCT = `LED_MIN_BRIGHTNESS,
    parameter int MAX_PCT = `LED_MAX_BRIGHTNESS
) (
    input  logic                sysclk,
    input  logic                i_rst,
    input  logic                i_enb,
    input  logic [CH*WIDTH-1:0] i_target,
    input  logic [CH-1:0]       i_ramp_en,
    input  logic [WIDTH-1:0]    i_step,
    output logic [CH-1:0]       o_pwm,
    output logic [WIDTH-1:0]    o_cnt,
    output logic [CH*WIDTH-1:0] o_duty,
    output logic [CH-1:0]       o_settled
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] BR_MIN  = WIDTH'(br_bound(WIDTH, MIN_PCT));
    localparam logic [WIDTH-1:0] BR_MAX  = WIDTH'(br_bound(WIDTH, MAX_PCT));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             boundary;

    always_comb begin
        boundary = i_enb && (cnt == CNT_MAX);
        cnt_next = i_enb ? cnt + WIDTH'(1) : CNT_MAX;
    end

    // Parking at full scale while disabled makes the first enabled cycle a boundary.
    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= CNT_MAX;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign o_cnt = cnt;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [WIDTH-1:0] ph_next;

`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [WIDTH-1:0] PH_OFFSET = WIDTH'(k * ((2 ** WIDTH) / CH));
        assign ph_next = cnt_next + PH_OFFSET;
`else
        assign ph_next = cnt_next;
`endif

        pwm_ramp_ch #(
            .WIDTH  (WIDTH),
            .BR_MIN (BR_MIN),
            .BR_MAX (BR_MAX)
        ) u_ch (
            .clk      (sysclk),
            .rst      (i_rst),
            .enb      (i_enb),
            .boundary (boundary),
            .cnt_cmp  (ph_next),
            .target   (i_target[k*WIDTH +: WIDTH]),
            .ramp_en  (i_ramp_en[k]),
            .step     (i_step),
            .pwm      (o_pwm[k]),
            .duty     (o_duty[k*WIDTH +: WIDTH]),
            .settled  (o_settled[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Bench for pwm_multi_ramp (CH=4, WIDTH=8, 10%..90% window): directed scenarios with
// literal expectations plus a per-cycle comparison against a behavioural period model.
module tb_pwm_multi_ramp;

    localparam int CH     = 4;
    localparam int W      = 8;
    localparam int NCNT   = 256;
    localparam int BR_MIN = 25;   // 255*10/100
    localparam int BR_MAX = 229;  // 255*90/100

    logic              sysclk = 1'b0;
    logic              i_rst;
    logic              i_enb;
    logic [CH*W-1:0]   i_target;
    logic [CH-1:0]     i_ramp_en;
    logic [W-1:0]      i_step;
    logic [CH-1:0]     o_pwm;
    logic [W-1:0]      o_cnt;
    logic [CH*W-1:0]   o_duty;
    logic [CH-1:0]     o_settled;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int         m_cnt;
    int         m_duty [CH];
    logic [CH-1:0] m_pwm;
    logic [CH-1:0] m_set;

    pwm_multi_ramp #(
        .CH      (CH),
        .WIDTH   (W),
        .MIN_PCT (10),
        .MAX_PCT (90)
    ) dut (
        .sysclk    (sysclk),
        .i_rst     (i_rst),
        .i_enb     (i_enb),
        .i_target  (i_target),
        .i_ramp_en (i_ramp_en),
        .i_step    (i_step),
        .o_pwm     (o_pwm),
        .o_cnt     (o_cnt),
        .o_duty    (o_duty),
        .o_settled (o_settled)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampc(input int t);
        return (t < BR_MIN) ? BR_MIN : ((t > BR_MAX) ? BR_MAX : t);
    endfunction

    // Period-level model: counter position, applied duty per channel, and the
    // output levels those imply one edge later.
    always @(posedge sysclk or posedge i_rst) begin : model
        int  nd;
        int  tc;
        int  s;
        int  ph;
        int  ncnt;
        bit  bnd;
        if (i_rst) begin
            m_cnt <= NCNT - 1;
            m_pwm <= '0;
            m_set <= '0;
            for (int k = 0; k < CH; k++) m_duty[k] <= 0;
        end else begin
            bnd  = i_enb && (m_cnt == NCNT - 1);
            ncnt = i_enb ? (m_cnt + 1) % NCNT : NCNT - 1;
            s    = (i_step == 0) ? 1 : int'(i_step);
            for (int k = 0; k < CH; k++) begin
                tc = clampc(int'(i_target[k*W +: W]));
                nd = m_duty[k];
                if (bnd) begin
                    if (!i_ramp_en[k])  nd = tc;
                    else if (nd < tc)   nd = (nd + s < tc) ? nd + s : tc;
                    else if (nd > tc)   nd = (nd - s > tc) ? nd - s : tc;
                end
`ifdef PWM_PHASE_STAGGER_EN
                ph = (ncnt + k * (NCNT / CH)) % NCNT;
`else
                ph = ncnt;
`endif
                m_pwm[k]  <= i_enb && (ph < nd);
                m_set[k]  <= (m_duty[k] == tc);
                m_duty[k] <= nd;
            end
            m_cnt <= ncnt;
        end
    end

    always @(negedge sysclk) begin : cmp
        logic [CH*W-1:0] pd;
        if (chk_en) begin
            for (int k = 0; k < CH; k++) pd[k*W +: W] = m_duty[k][W-1:0];
            chk("cyc_cnt", 32'(o_cnt), 32'(m_cnt[W-1:0]));
            chk("cyc_duty", o_duty, pd);
            chk("cyc_pwm", 32'(o_pwm), 32'(m_pwm));
            chk("cyc_settled", 32'(o_settled), 32'(m_set));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (o_cnt != W'(v) && n < 600);
        if (o_cnt != W'(v)) begin
            checks++;
            failures++;
            $display("FAIL wait_cnt_timeout actual=%0d required=%0d", o_cnt, v);
        end
    endtask

    task automatic next_period();
        wait_cnt(0);
    endtask

    initial begin : stim
        logic [CH*W-1:0] saved;
        int hi;
        int seq_exp [8] = '{35, 45, 55, 65, 75, 85, 95, 100};

        i_rst = 1'b1; i_enb = 1'b0; i_target = '0; i_ramp_en = '0; i_step = '0;
        @(posedge sysclk); #1;
        chk_en = 1'b1;
        tick(1);
        chk("rst_cnt", 32'(o_cnt), 255);
        chk("rst_pwm", 32'(o_pwm), 0);
        chk("rst_duty", o_duty, 0);
        chk("rst_settled", 32'(o_settled), 0);

        // Scenario 1: clamp with ramp off
        i_rst = 1'b0; i_enb = 1'b1;
        i_target = {8'd128, 8'd255, 8'd100, 8'd0};
        tick(1);
        chk("t1_duty", o_duty, {8'd128, 8'd229, 8'd100, 8'd25});
        chk("t1_cnt0", 32'(o_cnt), 0);
        hi = 0;
        for (int i = 0; i < NCNT; i++) begin
            hi += int'(o_pwm[1]);
            tick(1);
        end
        chk("t1_ch1_high", hi, 100);
        chk("t1_settled", 32'(o_settled), 32'hF);

        // Scenario 2: ramp up by 10 per period
        i_ramp_en[0] = 1'b1; i_step = 8'd10; i_target[7:0] = 8'd100;
        for (int i = 0; i < 8; i++) begin
            next_period();
            chk("t2_ramp", 32'(o_duty[7:0]), seq_exp[i]);
            if (i == 6) chk("t2_not_settled_95", 32'(o_settled[0]), 0);
        end
        chk("t2_settle_lag", 32'(o_settled[0]), 0);
        tick(1);
        chk("t2_settled", 32'(o_settled[0]), 1);

        // Scenario 3: mid-period target change waits for the boundary
        i_ramp_en[0] = 1'b0;
        next_period();
        hi = 0;
        for (int i = 0; i < NCNT; i++) begin
            hi += int'(o_pwm[3]);
            if (o_cnt == 8'd60) i_target[31:24] = 8'd50;
            tick(1);
        end
        chk("t3_old_width", hi, 128);
        hi = 0;
        for (int i = 0; i < NCNT; i++) begin
            hi += int'(o_pwm[3]);
            tick(1);
        end
        chk("t3_new_width", hi, 50);

        // Scenario 4: disable mid-period, then disable exactly on a boundary
        wait_cnt(100);
        saved = o_duty;
        i_enb = 1'b0;
        tick(1);
        chk("t4_cnt", 32'(o_cnt), 255);
        chk("t4_pwm", 32'(o_pwm), 0);
        i_target[15:8] = 8'd200;
        tick(5);
        chk("t4_frozen", o_duty, saved);
        i_enb = 1'b1;
        tick(1);
        chk("t4_restart_cnt", 32'(o_cnt), 0);
        chk("t4_restart_duty", 32'(o_duty[15:8]), 200);
        i_target[15:8] = 8'd60;
        wait_cnt(255);
        i_enb = 1'b0;
        tick(1);
        chk("t4_disable_wins", 32'(o_duty[15:8]), 200);
        i_enb = 1'b1;
        tick(1);
        chk("t4_reenable_update", 32'(o_duty[15:8]), 60);

        // Scenario 5: asynchronous reset in the middle of a ramp
        i_ramp_en[2] = 1'b1; i_step = 8'd5; i_target[23:16] = 8'd100;
        tick(300);
        #2 i_rst = 1'b1;
        #1;
        chk("t5_async_pwm", 32'(o_pwm), 0);
        chk("t5_async_duty", o_duty, 0);
        chk("t5_async_settled", 32'(o_settled), 0);
        chk("t5_async_cnt", 32'(o_cnt), 255);
        @(posedge sysclk); #1;
        i_rst = 1'b0;
        tick(1);
        chk("t5_resume_cnt", 32'(o_cnt), 0);
        chk("t5_resume_duty", o_duty, {8'd50, 8'd5, 8'd60, 8'd100});

        // Scenario 6: zero step ramps by one count per period
        i_ramp_en[0] = 1'b0; i_target[7:0] = 8'd0;
        next_period();
        chk("t6_start", 32'(o_duty[7:0]), 25);
        i_ramp_en[0] = 1'b1; i_target[7:0] = 8'd30; i_step = 8'd0;
        for (int i = 0; i < 5; i++) begin
            next_period();
            chk("t6_ramp", 32'(o_duty[7:0]), 26 + i);
        end
        next_period();
        chk("t6_hold", 32'(o_duty[7:0]), 30);

        tick(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
